// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch
//  Purpose  : Instruction fetch stage. Owns the fetch PC, issues word fetches
//             over a req/gnt + in-order rvalid interface, buffers returned
//             words in a DEPTH-entry FIFO and presents them to the decoder
//             under valid/ready. A redirect flushes the FIFO and marks all
//             in-flight fetches to be dropped when they return.
//  Ports    : clk, rst                    - clock, sync active-high reset
//             imem_req/addr/gnt           - fetch request channel
//             imem_rvalid/rdata           - in-order fetch responses
//             instr_valid/instr/instr_pc  - FIFO head towards the decoder
//             instr_ready                 - decoder pop
//             redirect/redirect_pc        - branch/jump restart
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned C_CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned C_PTR_W = $clog2(DEPTH);
  localparam logic [C_CNT_W:0] C_DEPTH_EXT = (C_CNT_W + 1)'(DEPTH);

  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        resp_pc_q, resp_pc_d;
  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_CNT_W-1:0] count_q, count_d;
  logic [C_CNT_W-1:0] outstanding_q, outstanding_d;
  logic [C_CNT_W-1:0] drop_q, drop_d;
  logic [31:0]        fifo_instr_q [DEPTH];
  logic [31:0]        fifo_pc_q    [DEPTH];

  logic               w_pop;
  logic               w_rsp;
  logic               w_grant;
  logic               w_push;
  logic [C_CNT_W:0]   w_used;
  logic               w_unused_ok;

  // Low bits of the redirect target are architecturally ignored.
  assign w_unused_ok = ^redirect_pc[1:0];

  assign instr_valid = (count_q != '0);
  assign instr       = fifo_instr_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];

  assign w_pop = instr_valid && instr_ready;
  // A response with nothing outstanding is a protocol violation: ignore it.
  assign w_rsp = imem_rvalid && (outstanding_q != '0);

  // Credit: every in-flight fetch (dropped ones included) plus every buffered
  // word owns a FIFO slot, so responses can never overflow the FIFO.
  assign w_used   = {1'b0, outstanding_q} + {1'b0, count_q}
                  - {{C_CNT_W{1'b0}}, w_pop};
  assign imem_req  = !rst && !redirect && (w_used < C_DEPTH_EXT);
  assign imem_addr = fetch_pc_q;
  assign w_grant   = imem_req && imem_gnt;
  assign w_push    = w_rsp && (drop_q == '0) && !redirect;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + C_CNT_W'(w_grant) - C_CNT_W'(w_rsp);

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d     = outstanding_q - C_CNT_W'(w_rsp);
    end else begin
      if (w_grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (w_rsp && (drop_q != '0)) begin
        drop_d = drop_q - C_CNT_W'(1);
      end
      if (w_push) begin
        wr_ptr_d  = wr_ptr_q + C_PTR_W'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end
      count_d = count_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Storage needs no reset: contents are only observed while count_q != 0.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule
`default_nettype wire
